// File: rtl/neuron_mac_if.sv
// Stream and status bundle between the neuron MAC and its driver/consumer.
interface neuron_mac_if;
   logic        start;
   logic [31:0] bias;
   logic [31:0] x;
   logic [31:0] w;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] result;
   logic        out_valid;
   logic        out_ready;
   logic        overflow;
   logic        busy;

   modport master (
      output start, bias, x, w, in_valid, out_ready,
      input  in_ready, result, out_valid, overflow, busy
   );

   modport slave (
      input  start, bias, x, w, in_valid, out_ready,
      output in_ready, result, out_valid, overflow, busy
   );
endinterface

// File: rtl/neuron_mac.sv
// Sequential Q16.16 neuron: result = act(bias + sum x[i]*w[i]) with a registered
// multiplier stage, a saturating accumulator and a sticky overflow flag.
module neuron_mac #(
   parameter int unsigned N_INPUTS = 8,
   parameter bit          RELU     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   neuron_mac_if.slave bus
);
   localparam int unsigned DW = 32;
   localparam int unsigned PW = 64;
   localparam int unsigned CW = $clog2(N_INPUTS + 1);
   localparam logic [DW-1:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [DW-1:0] SAT_MIN = 32'h8000_0000;
   localparam logic [CW-1:0] LAST_COUNT = CW'(N_INPUTS - 1);

   typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, DONE} state_t;

   state_t            state;
   logic [DW-1:0]     acc;
   logic [DW-1:0]     bias_q;
   logic [DW-1:0]     prod_q;
   logic              prod_v;
   logic [CW-1:0]     count;

   logic signed [PW-1:0] x_ext;
   logic signed [PW-1:0] w_ext;
   logic signed [PW-1:0] prod_full;
   logic                 mul_sat;
   logic [DW-1:0]        mul_q;
   logic [DW:0]          acc_add;
   logic [DW:0]          bias_add;
   logic [DW-1:0]        act_out;
   logic                 unused_lsb;

   // Signed add clamped to the 32-bit range; MSB of the return is the saturation flag.
   function automatic logic [DW:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] s;
      s = a + b;
      if ((a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]))
         sat_add = {1'b1, a[DW-1] ? SAT_MIN : SAT_MAX};
      else
         sat_add = {1'b0, s};
   endfunction

   // Full-width product, Q16.16 extraction with clamping, and the two saturating adders.
   always_comb begin
      x_ext      = {{DW{bus.x[DW-1]}}, bus.x};
      w_ext      = {{DW{bus.w[DW-1]}}, bus.w};
      prod_full  = x_ext * w_ext;
      unused_lsb = ^prod_full[15:0];
      // Bits 63..47 must all agree for the shifted product to fit in 32 bits.
      mul_sat    = !((&prod_full[63:47]) || !(|prod_full[63:47]));
      mul_q      = prod_full[47:16];
      if (mul_sat)
         mul_q = prod_full[PW-1] ? SAT_MIN : SAT_MAX;
      acc_add    = sat_add(acc, prod_q);
      bias_add   = sat_add(acc, bias_q);
      act_out    = (RELU && bias_add[DW-1]) ? '0 : bias_add[DW-1:0];
   end

   // Control FSM, product pipeline register, accumulator and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         acc           <= '0;
         bias_q        <= '0;
         prod_q        <= '0;
         prod_v        <= 1'b0;
         count         <= '0;
         bus.in_ready  <= 1'b0;
         bus.result    <= '0;
         bus.out_valid <= 1'b0;
         bus.overflow  <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         prod_v <= 1'b0;
         // A pending product folds into the accumulator regardless of state.
         if (prod_v) begin
            acc <= acc_add[DW-1:0];
            if (acc_add[DW])
               bus.overflow <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (bus.start) begin
                  acc          <= '0;
                  count        <= '0;
                  bus.overflow <= 1'b0;
                  bias_q       <= bus.bias;
                  bus.in_ready <= 1'b1;
                  bus.busy     <= 1'b1;
                  state        <= ACCUM;
               end
            end
            ACCUM: begin
               if (bus.in_valid && bus.in_ready) begin
                  prod_q <= mul_q;
                  prod_v <= 1'b1;
                  count  <= count + CW'(1);
                  if (mul_sat)
                     bus.overflow <= 1'b1;
                  if (count == LAST_COUNT) begin
                     bus.in_ready <= 1'b0;
                     state        <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               state <= BIAS;
            end
            BIAS: begin
               bus.result    <= act_out;
               bus.out_valid <= 1'b1;
               if (bias_add[DW])
                  bus.overflow <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.busy      <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: a ReLU and a pass-through instance share one stimulus stream;
// table vectors, hand-written corner sequences and random evaluations are checked
// against an arithmetic reference model.
module tb_neuron_mac;
   localparam int unsigned N = 8;

   typedef struct {
      string       name;
      logic [31:0] x0;
      logic [31:0] w0;
      logic [31:0] x;
      logic [31:0] w;
      logic [31:0] bias;
      logic [31:0] exp_relu;
      logic [31:0] exp_pass;
      logic        exp_ovf;
      bit          gap;
      int          hold;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   neuron_mac_if bus_r ();
   neuron_mac_if bus_p ();

   assign bus_p.start     = bus_r.start;
   assign bus_p.bias      = bus_r.bias;
   assign bus_p.x         = bus_r.x;
   assign bus_p.w         = bus_r.w;
   assign bus_p.in_valid  = bus_r.in_valid;
   assign bus_p.out_ready = bus_r.out_ready;

   neuron_mac #(.N_INPUTS(N), .RELU(1'b1)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));
   neuron_mac #(.N_INPUTS(N), .RELU(1'b0)) dut_p (.clk(clk), .rst(rst), .bus(bus_p));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference arithmetic: exact products and sums in 64-bit, clipped to 32-bit range.
   function automatic bit out_of_range(input longint v);
      return (v > 64'sd2147483647) || (v < -64'sd2147483648);
   endfunction

   function automatic longint clip(input longint v);
      if (v > 64'sd2147483647)  return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
   endfunction

   function automatic void ref_model(input logic [31:0] xs [N], input logic [31:0] ws [N],
                                     input logic [31:0] b, input bit relu,
                                     output logic [31:0] r, output logic ov);
      longint acc;
      longint p;
      longint q;
      acc = 0;
      ov  = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         p = longint'($signed(xs[i])) * longint'($signed(ws[i]));
         q = p >>> 16;
         if (out_of_range(q)) ov = 1'b1;
         q   = clip(q);
         acc = acc + q;
         if (out_of_range(acc)) ov = 1'b1;
         acc = clip(acc);
      end
      acc = acc + longint'($signed(b));
      if (out_of_range(acc)) ov = 1'b1;
      acc = clip(acc);
      r = (relu && acc < 0) ? 32'h0 : 32'(acc);
   endfunction

   function automatic vec_t mk(input string nm, input logic [31:0] x0, input logic [31:0] w0,
                               input logic [31:0] x, input logic [31:0] w, input logic [31:0] b,
                               input logic [31:0] er, input logic [31:0] ep, input logic eo,
                               input bit gap, input int hold);
      vec_t v;
      v.name = nm; v.x0 = x0; v.w0 = w0; v.x = x; v.w = w; v.bias = b;
      v.exp_relu = er; v.exp_pass = ep; v.exp_ovf = eo; v.gap = gap; v.hold = hold;
      return v;
   endfunction

   // Caller is at a falling edge; start is seen on the next rising edge.
   task automatic send_start(input logic [31:0] b);
      bus_r.start = 1'b1;
      bus_r.bias  = b;
      @(negedge clk);
      bus_r.start = 1'b0;
      check("busy_after_start", 32'(bus_r.busy), 32'h1);
   endtask

   task automatic send_beat(input logic [31:0] xv, input logic [31:0] wv);
      int waited;
      waited = 0;
      bus_r.x        = xv;
      bus_r.w        = wv;
      bus_r.in_valid = 1'b1;
      while (!bus_r.in_ready && waited < 16) begin
         @(negedge clk);
         waited++;
      end
      check("in_ready_for_beat", 32'(bus_r.in_ready), 32'h1);
      @(negedge clk);
   endtask

   task automatic run_eval(input string tag, input logic [31:0] xs [N], input logic [31:0] ws [N],
                           input logic [31:0] b, input bit gap, input int hold,
                           input int pulse_at, input bit start_on_release,
                           output logic [31:0] r1, output logic [31:0] r0,
                           output logic o1, output logic o0);
      send_start(b);
      for (int i = 0; i < int'(N); i++) begin
         if (i == pulse_at) begin
            bus_r.in_valid = 1'b0;
            bus_r.start    = 1'b1;
            bus_r.bias     = 32'h1234_0000;
            @(negedge clk);
            bus_r.start = 1'b0;
            check({tag, "_busy_after_stray_start"}, 32'(bus_r.busy), 32'h1);
         end
         send_beat(xs[i], ws[i]);
         if (gap && i != int'(N) - 1) begin
            bus_r.in_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check({tag, "_in_ready_in_bubble"}, 32'(bus_r.in_ready), 32'h1);
         end
      end
      bus_r.in_valid = 1'b0;
      check({tag, "_in_ready_after_last"}, 32'(bus_r.in_ready), 32'h0);
      check({tag, "_out_valid_t1"}, 32'(bus_r.out_valid), 32'h0);
      @(negedge clk);
      check({tag, "_out_valid_t2"}, 32'(bus_r.out_valid), 32'h0);
      @(negedge clk);
      check({tag, "_out_valid_t3"}, 32'(bus_r.out_valid), 32'h1);
      check({tag, "_out_valid_t3_pass"}, 32'(bus_p.out_valid), 32'h1);
      r1 = bus_r.result;
      r0 = bus_p.result;
      o1 = bus_r.overflow;
      o0 = bus_p.overflow;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check({tag, "_out_valid_held"}, 32'(bus_r.out_valid), 32'h1);
         check({tag, "_result_stable"}, bus_r.result, r1);
      end
      bus_r.out_ready = 1'b1;
      if (start_on_release) bus_r.start = 1'b1;
      @(negedge clk);
      bus_r.out_ready = 1'b0;
      bus_r.start     = 1'b0;
      check({tag, "_out_valid_cleared"}, 32'(bus_r.out_valid), 32'h0);
      check({tag, "_busy_cleared"}, 32'(bus_r.busy), 32'h0);
      check({tag, "_result_kept"}, bus_r.result, r1);
      if (start_on_release) begin
         @(negedge clk);
         check({tag, "_still_idle"}, 32'(bus_r.busy), 32'h0);
         check({tag, "_no_second_result"}, 32'(bus_r.out_valid), 32'h0);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[$];
      logic [31:0] xs [N];
      logic [31:0] ws [N];
      logic [31:0] r1, r0, e1, e0, b;
      logic        o1, o0, eo1, eo0;
      int          t;

      bus_r.start = 1'b0; bus_r.bias = '0; bus_r.x = '0; bus_r.w = '0;
      bus_r.in_valid = 1'b0; bus_r.out_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_result", bus_r.result, 32'h0);
      check("reset_out_valid", 32'(bus_r.out_valid), 32'h0);
      check("reset_in_ready", 32'(bus_r.in_ready), 32'h0);
      check("reset_overflow", 32'(bus_r.overflow), 32'h0);
      check("reset_busy", 32'(bus_r.busy), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      tbl.push_back(mk("ones_x_2p5", 32'h0001_0000, 32'h0002_8000, 32'h0001_0000, 32'h0002_8000,
                       32'h0, 32'h0014_0000, 32'h0014_0000, 1'b0, 1'b0, 0));
      tbl.push_back(mk("neg_relu", 32'hFFFE_8000, 32'h0001_0000, 32'hFFFE_8000, 32'h0001_0000,
                       32'h0001_0000, 32'h0, 32'hFFF5_0000, 1'b0, 1'b0, 1));
      tbl.push_back(mk("mul_sat_pos", 32'h7FFF_0000, 32'h0002_0000, 32'h0, 32'h0,
                       32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 0));
      tbl.push_back(mk("ovf_cleared", 32'h0000_8000, 32'h0001_0000, 32'h0000_8000, 32'h0001_0000,
                       32'h0, 32'h0004_0000, 32'h0004_0000, 1'b0, 1'b0, 0));
      tbl.push_back(mk("backpressure", 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000,
                       32'h0, 32'h0002_0000, 32'h0002_0000, 1'b0, 1'b1, 5));
      tbl.push_back(mk("mul_sat_neg", 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0,
                       32'h0, 32'h0, 32'h8000_0000, 1'b1, 1'b0, 0));
      tbl.push_back(mk("acc_sat", 32'h1000_0000, 32'h0001_0000, 32'h1000_0000, 32'h0001_0000,
                       32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 0));
      tbl.push_back(mk("bias_sat", 32'h0F00_0000, 32'h0001_0000, 32'h0F00_0000, 32'h0001_0000,
                       32'h1000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 0));
      tbl.push_back(mk("trunc_floor", 32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_FFFF, 32'h0000_8000,
                       32'h0, 32'h0, 32'hFFFF_FFF8, 1'b0, 1'b0, 0));
      tbl.push_back(mk("exact_min", 32'hF000_0000, 32'h0001_0000, 32'hF000_0000, 32'h0001_0000,
                       32'h0, 32'h0, 32'h8000_0000, 1'b0, 1'b1, 2));

      foreach (tbl[j]) begin
         xs[0] = tbl[j].x0;
         ws[0] = tbl[j].w0;
         for (int i = 1; i < int'(N); i++) begin
            xs[i] = tbl[j].x;
            ws[i] = tbl[j].w;
         end
         run_eval(tbl[j].name, xs, ws, tbl[j].bias, tbl[j].gap, tbl[j].hold, -1, 1'b0, r1, r0, o1, o0);
         check({tbl[j].name, "_result_relu"}, r1, tbl[j].exp_relu);
         check({tbl[j].name, "_result_pass"}, r0, tbl[j].exp_pass);
         check({tbl[j].name, "_overflow"}, 32'(o1), 32'(tbl[j].exp_ovf));
         check({tbl[j].name, "_overflow_pass"}, 32'(o0), 32'(tbl[j].exp_ovf));
      end

      // Reset in the middle of an evaluation discards everything.
      for (int i = 0; i < int'(N); i++) begin
         xs[i] = 32'h0001_0000;
         ws[i] = 32'h0002_8000;
      end
      send_start(32'h0);
      for (int i = 0; i < 3; i++) send_beat(xs[i], ws[i]);
      bus_r.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(bus_r.busy), 32'h0);
      check("abort_out_valid", 32'(bus_r.out_valid), 32'h0);
      check("abort_result", bus_r.result, 32'h0);
      check("abort_result_pass", bus_p.result, 32'h0);
      check("abort_in_ready", 32'(bus_r.in_ready), 32'h0);
      check("abort_overflow", 32'(bus_r.overflow), 32'h0);
      @(negedge clk);
      run_eval("after_abort", xs, ws, 32'h0, 1'b0, 0, -1, 1'b0, r1, r0, o1, o0);
      check("after_abort_result", r1, 32'h0014_0000);
      check("after_abort_overflow", 32'(o1), 32'h0);

      // Stray start mid-stream and start coincident with out_ready in DONE are ignored.
      run_eval("stray_start", xs, ws, 32'h0, 1'b0, 2, 3, 1'b1, r1, r0, o1, o0);
      check("stray_start_result", r1, 32'h0014_0000);
      check("stray_start_result_pass", r0, 32'h0014_0000);

      // Random evaluations against the reference model.
      for (int e = 0; e < 40; e++) begin
         for (int i = 0; i < int'(N); i++) begin
            t = int'($urandom);
            xs[i] = 32'(t >>> $urandom_range(0, 16));
            t = int'($urandom);
            ws[i] = 32'(t >>> $urandom_range(4, 20));
         end
         t = int'($urandom);
         b = 32'(t >>> $urandom_range(0, 20));
         ref_model(xs, ws, b, 1'b1, e1, eo1);
         ref_model(xs, ws, b, 1'b0, e0, eo0);
         run_eval("rand", xs, ws, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  -1, 1'b0, r1, r0, o1, o0);
         check("rand_result_relu", r1, e1);
         check("rand_result_pass", r0, e0);
         check("rand_overflow_relu", 32'(o1), 32'(eo1));
         check("rand_overflow_pass", 32'(o0), 32'(eo0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
